// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared types for the alarm trigger block.
//   bcd_t         : one 4-bit BCD digit
//   hhmm_t        : {hh_tens, hh_ones, mm_tens, mm_ones}, packed to 16 bits
//   alarm_state_t : trigger FSM states
//   timer_width() : register width for a counter, never below 1 bit
// -----------------------------------------------------------------------------
package alarm_pkg;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t hh_tens;
      bcd_t hh_ones;
      bcd_t mm_tens;
      bcd_t mm_ones;
   } hhmm_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZE  = 2'd2
   } alarm_state_t;

   // $clog2 returns 0 for an argument of 1.
   // A zero-width vector is illegal, so clamp the result to at least 1 bit.
   function automatic int timer_width(input int max_val);
      return (max_val > 1) ? $clog2(max_val) : 1;
   endfunction

endpackage

// File: rtl/alarm_match.sv
// -----------------------------------------------------------------------------
// alarm_match
// Compares the running HH:MM against the alarm setting.
// Emits a one-cycle trigger on the first cycle of a matching minute.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   time_digits  in   running time, hhmm_t
//   alarm_digits in   alarm setting, hhmm_t
//   alarm_en     in   alarm armed
//   trig         out  rising edge of the match, qualified by alarm_en
// -----------------------------------------------------------------------------
module alarm_match
   import alarm_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  hhmm_t time_digits,
   input  hhmm_t alarm_digits,
   input  logic  alarm_en,
   output logic  trig
);

   logic match;
   logic match_q;

   // Plain 16-bit equality; out-of-range BCD codes are compared as-is.
   assign match = (time_digits == alarm_digits);

   // match_q comes out of reset as 1.
   // This stops a time that already equals the alarm at reset release from
   // looking like a new match.
   // NOTE: state registers are written with <= so every flop samples the
   // pre-edge values; blocking assignments here would create order-dependent
   // simulation that no longer matches the synthesized hardware.
   always_ff @(posedge clk) begin
      if (reset) begin
         match_q <= 1'b1;
      end else begin
         match_q <= match;
      end
   end

   // Fires only on the first cycle of the matching minute.
   // Stopping the alarm inside that minute therefore does not re-arm it.
   assign trig = match & ~match_q & alarm_en;

endmodule

// File: rtl/alarm_trigger.sv
// -----------------------------------------------------------------------------
// alarm_trigger
// Raises the ring output when the time reaches the alarm setting.
// It then handles snooze, stop and the unattended-ringing timeout.
// Timers advance on the 1 Hz sec_tick.
// Optional build macro ALARM_TRIG_BEEP_EN:
//   defined   : buzzer beeps 1 s on / 1 s off while ringing
//   undefined : buzzer follows ringing (continuous tone)
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   sec_tick     in   one-cycle pulse per second
//   time_digits  in   {hh_tens, hh_ones, mm_tens, mm_ones} BCD
//   alarm_digits in   same packing, from the alarm setting registers
//   alarm_en     in   alarm armed (level)
//   snooze_btn   in   debounced snooze button level
//   stop_btn     in   debounced stop button level
//   ringing      out  high while ringing
//   snoozing     out  high while snoozing
//   buzzer       out  buzzer drive
//   snooze_count out  snoozes used in the current alarm event
// -----------------------------------------------------------------------------
module alarm_trigger
   import alarm_pkg::*;
#(
   parameter int SNOOZE_SEC       = 300,
   parameter int RING_TIMEOUT_SEC = 120,
   parameter int MAX_SNOOZES      = 3
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        sec_tick,
   input  logic [15:0] time_digits,
   input  logic [15:0] alarm_digits,
   input  logic        alarm_en,
   input  logic        snooze_btn,
   input  logic        stop_btn,
   output logic        ringing,
   output logic        snoozing,
   output logic        buzzer,
   output logic [3:0]  snooze_count
);

   localparam int SNZ_W  = timer_width(SNOOZE_SEC + 1);
   localparam int RING_W = timer_width(RING_TIMEOUT_SEC);

   localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SEC);
   localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);
   localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_SEC - 1);
   localparam logic [3:0]        SNZ_MAX   = 4'(MAX_SNOOZES);

   alarm_state_t      state;
   logic [SNZ_W-1:0]  snz_timer;
   logic [RING_W-1:0] ring_sec;
   logic              snooze_btn_q;
   logic              stop_btn_q;
   logic              trig;
   logic              snz_p;
   logic              stp_p;

   alarm_match u_match (
      .clk          (clk),
      .reset        (reset),
      .time_digits  (time_digits),
      .alarm_digits (alarm_digits),
      .alarm_en     (alarm_en),
      .trig         (trig)
   );

   // The edge registers reset to 1.
   // A button already held at reset release therefore does not count as a press.
   assign snz_p = snooze_btn & ~snooze_btn_q;
   assign stp_p = stop_btn & ~stop_btn_q;

   // Outputs are updated together with state on every transition.
   // They are therefore registered decodes of the state just entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         ringing      <= 1'b0;
         snoozing     <= 1'b0;
         buzzer       <= 1'b0;
         snooze_count <= '0;
         ring_sec     <= '0;
         snz_timer    <= '0;
         snooze_btn_q <= 1'b1;
         stop_btn_q   <= 1'b1;
      end else begin
         snooze_btn_q <= snooze_btn;
         stop_btn_q   <= stop_btn;

         case (state)
            ST_IDLE: begin
               if (trig) begin
                  state        <= ST_RINGING;
                  ring_sec     <= '0;
                  snooze_count <= '0;
                  ringing      <= 1'b1;
                  buzzer       <= 1'b1;
               end
            end

            ST_RINGING: begin
               if (!alarm_en || stp_p) begin
                  state   <= ST_IDLE;
                  ringing <= 1'b0;
                  buzzer  <= 1'b0;
               end else if (snz_p && (snooze_count < SNZ_MAX)) begin
                  state        <= ST_SNOOZE;
                  snz_timer    <= SNZ_LOAD;
                  snooze_count <= snooze_count + 4'd1;
                  ringing      <= 1'b0;
                  snoozing     <= 1'b1;
                  buzzer       <= 1'b0;
               end else if (sec_tick) begin
                  // A snooze press with no snoozes left falls through to here.
                  if (ring_sec == RING_LAST) begin
                     state   <= ST_IDLE;
                     ringing <= 1'b0;
                     buzzer  <= 1'b0;
                  end else begin
                     ring_sec <= ring_sec + 1'b1;
`ifdef ALARM_TRIG_BEEP_EN
                     buzzer   <= ~buzzer;
`endif
                  end
               end
            end

            ST_SNOOZE: begin
               if (!alarm_en || stp_p) begin
                  state    <= ST_IDLE;
                  snoozing <= 1'b0;
               end else if (sec_tick) begin
                  if (snz_timer == SNZ_ONE) begin
                     state    <= ST_RINGING;
                     ring_sec <= '0;
                     ringing  <= 1'b1;
                     snoozing <= 1'b0;
                     buzzer   <= 1'b1;
                  end else begin
                     snz_timer <= snz_timer - 1'b1;
                  end
               end
            end

            default: begin
               state    <= ST_IDLE;
               ringing  <= 1'b0;
               snoozing <= 1'b0;
               buzzer   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/alarm_trigger.md
Name: alarm_trigger

Overview:
- Reads the four BCD alarm digits held by the alarm setting registers and compares them every cycle against the running HH:MM time digits.
- When the time first matches the alarm, it raises the ring output. It then manages snooze, stop and auto-timeout.
- It sits between the alarm/time digit registers and the buzzer/LED driver, and is timed by the 1 Hz sec_tick from the timebase.

Parameters:
- SNOOZE_SEC, 300: seconds spent in snooze before the alarm re-rings.
- RING_TIMEOUT_SEC, 120: seconds of unattended ringing before auto-off.
- MAX_SNOOZES, 3: snoozes allowed per alarm event. Range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sec_tick  in  1  one-cycle pulse, once per second.
- time_digits  in  16  {hh_tens, hh_ones, mm_tens, mm_ones}, 4-bit BCD each.
- alarm_digits  in  16  same packing, taken from the alarm setting registers.
- alarm_en  in  1  alarm armed; level signal.
- snooze_btn  in  1  debounced snooze button level.
- stop_btn  in  1  debounced stop button level.
- ringing  out  1  high while in RINGING.
- snoozing  out  1  high while in SNOOZE.
- buzzer  out  1  buzzer drive.
- snooze_count  out  4  snoozes used in the current event.

Behaviour:
- Single clock (clk). Reset is synchronous and active-high (reset). Everything updates on the rising edge of clk only.
- Reset values: state=IDLE, ringing=0, snoozing=0, buzzer=0, snooze_count=0, timers=0, button edge registers=1.
- match_q also resets to 1. This suppresses a spurious trigger when time already equals the alarm as reset deasserts.
- match = (time_digits == alarm_digits). This is a full 16-bit equality; digits are not range-checked.
- match_q <= match every cycle.
- trig = match & ~match_q & alarm_en. It fires only on the first cycle of a matching minute, so stopping the alarm inside the matching minute does not re-trigger it.
- Buttons are rising-edge detected internally: snz_p = snooze_btn & ~snooze_btn_q, stp_p likewise. Holding a button acts once.
- FSM states: IDLE, RINGING, SNOOZE. All outputs are registered decodes of the state, giving one cycle of latency from cause to output.
- IDLE:
  - trig -> RINGING; ring_sec=0, snooze_count=0.
  - All other inputs are ignored.
- RINGING (priority order, highest first):
  - ~alarm_en -> IDLE.
  - stp_p -> IDLE.
  - snz_p with snooze_count<MAX_SNOOZES -> SNOOZE; snz_timer=SNOOZE_SEC, snooze_count+1.
  - snz_p with snooze_count==MAX_SNOOZES -> ignored; stays RINGING.
  - sec_tick with ring_sec==RING_TIMEOUT_SEC-1 -> IDLE (auto-off).
  - Otherwise sec_tick increments ring_sec.
- SNOOZE (priority order, highest first):
  - ~alarm_en -> IDLE.
  - stp_p -> IDLE.
  - sec_tick with snz_timer==1 -> RINGING; ring_sec=0.
  - Otherwise sec_tick decrements snz_timer.
  - snz_p is ignored.
- trig while in RINGING or SNOOZE is ignored; there is no restart.
- Simultaneous events resolve in the priority order listed for each state.
- snooze_count holds its value in IDLE until the next trig clears it.
- Timer widths: $clog2(SNOOZE_SEC+1) and $clog2(RING_TIMEOUT_SEC). Neither timer wraps.
- Reset mid-operation returns to IDLE immediately and clears all timers.

Optional Feature:
- Macro: ALARM_TRIG_BEEP_EN.
- Defined:
  - buzzer is set to 1 on entry to RINGING.
  - It toggles on each sec_tick while RINGING, giving 1 s on / 1 s off.
  - It is forced to 0 in every other state.
- Undefined: buzzer = ringing (continuous tone).

Decomposition:
- Package alarm_pkg holds:
  - typedef bcd_t: logic[3:0].
  - typedef hhmm_t: packed struct of 4 bcd_t.
  - enum alarm_state_t: ST_IDLE=2'd0, ST_RINGING=2'd1, ST_SNOOZE=2'd2.
- One sub-module, alarm_match, contains the equality compare, the match_q register and the trig generation with the alarm_en qualifier. The FSM and timers stay in alarm_trigger.

Test Plan:
Bench parameters: SNOOZE_SEC=3, RING_TIMEOUT_SEC=4, MAX_SNOOZES=2.
1. alarm=07:30, alarm_en=1, time steps 07:29 -> 07:30 -> ringing=1 one cycle after the change; snooze_count=0.
2. Ringing; pulse stop_btn while time stays 07:30 for 10 more cycles -> ringing=0 next cycle, no re-trigger; time to 07:31 then back to 07:30 -> rings again.
3. Ringing; snooze_btn -> snoozing=1, snooze_count=1. After 3 sec_ticks -> ringing=1. Snooze again -> count=2. After 3 ticks it rings. Third snooze -> ignored, stays ringing.
4. Ringing, no buttons -> 4th sec_tick returns to IDLE (ringing=0); with ALARM_TRIG_BEEP_EN, buzzer sequence is 1,0,1,0 across the ticks.
5. Same cycle: snooze_btn rise + stop_btn rise -> IDLE. Same cycle: sec_tick timeout + snooze rise -> SNOOZE.
6. Assert reset with time==alarm=12:00 and alarm_en=1, release -> no ringing during 12:00. Reset pulsed during SNOOZE -> IDLE, snooze_count=0.
